// File: rtl/div_pkg.sv
// Shared types and constants for the divider issue controller.
// Holds the FSM encoding, quotient saturation values and the width helper.
package div_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LAUNCH = 3'd1,
      WAIT   = 3'd2,
      BYPASS = 3'd3,
      RESULT = 3'd4,
      GAP    = 3'd5
   } state_e;

   localparam int unsigned QW = 32;
   localparam logic [QW-1:0] QMAX = {1'b0, {(QW-1){1'b1}}};
   localparam logic [QW-1:0] QMIN = {1'b1, {(QW-1){1'b0}}};

   // Bits needed to index n entries (ceil(log2(n))).
   function automatic int unsigned clogb2(input int unsigned n);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++)
         if ((64'd1 << i) < 64'(n)) r = i + 1;
      return r;
   endfunction

endpackage

// File: rtl/div_req_fifo.sv
// Request buffer in front of the divider: synchronous, first-word-fall-through.
// A write while full is accepted only when a read frees a slot in the same cycle.
module div_req_fifo
   import div_pkg::*;
#(
   parameter int unsigned WIDTH = 68,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             wr_en_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic             rd_en_i,
   output logic [WIDTH-1:0] rd_data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned AW = clogb2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q, rptr_q;
   logic [AW:0]      cnt_q;
   logic             do_wr, do_rd;

   assign full_o    = (cnt_q == FULL_CNT);
   assign empty_o   = (cnt_q == '0);
   assign do_rd     = rd_en_i & ~empty_o;
   assign do_wr     = wr_en_i & (~full_o | do_rd);
   assign rd_data_o = mem_q[rptr_q];

   always_ff @(posedge clk) begin
      if (!rstn) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (do_wr) wptr_q <= wptr_q + 1'b1;
         if (do_rd) rptr_q <= rptr_q + 1'b1;
         case ({do_wr, do_rd})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem_q[wptr_q] <= wr_data_i;
   end

endmodule

// File: rtl/div_issue_ctrl.sv
// Issue stage for the 48-cycle signed fixed-point divider: buffers requests,
// launches one division at a time, resolves divide-by-zero locally, returns tagged results.
module div_issue_ctrl
   import div_pkg::*;
#(
   parameter int unsigned DIVISION_WIDTH   = 32,
   parameter int unsigned QUOTIENT_WIDTH   = QW,
   parameter int unsigned FRACTIONAL_WIDTH = 16,
   parameter int unsigned TAG_WIDTH        = 4,
   parameter int unsigned FIFO_DEPTH       = 4,
   parameter int unsigned TIMEOUT          = 64
) (
   input  logic                        clk,
   input  logic                        rstn,
   input  logic                        s_valid,
   output logic                        s_ready,
   input  logic [DIVISION_WIDTH-1:0]   s_dividend,
   input  logic [DIVISION_WIDTH-1:0]   s_divisor,
   input  logic [TAG_WIDTH-1:0]        s_tag,
   output logic                        div_start,
   output logic [DIVISION_WIDTH-1:0]   div_dividend,
   output logic [DIVISION_WIDTH-1:0]   div_divisor,
   input  logic [QUOTIENT_WIDTH-1:0]   div_quotient,
   input  logic [FRACTIONAL_WIDTH-1:0] div_fractional,
   input  logic                        div_finish,
   output logic                        m_valid,
   input  logic                        m_ready,
   output logic [QUOTIENT_WIDTH-1:0]   m_quotient,
   output logic [FRACTIONAL_WIDTH-1:0] m_fractional,
   output logic [TAG_WIDTH-1:0]        m_tag,
   output logic                        m_dbz,
   output logic                        m_timeout,
   output logic                        m_range
);

   localparam int unsigned DW = DIVISION_WIDTH;
   localparam int unsigned EW = 2*DW + TAG_WIDTH;
   localparam int unsigned CW = clogb2(TIMEOUT);
   localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
   localparam logic [DW-1:0] MOST_NEG = {1'b1, {(DW-1){1'b0}}};

   state_e state_q, state_d;

   logic                 fifo_full, fifo_empty, push, pop;
   logic [EW-1:0]        head;
   logic [DW-1:0]        h_dvd, h_dvs;
   logic [TAG_WIDTH-1:0] h_tag;

   logic [DW-1:0]               dvd_q, dvs_q;
   logic [TAG_WIDTH-1:0]        tag_q;
   logic                        rng_q, dbz_q, to_q;
   logic [QUOTIENT_WIDTH-1:0]   quo_q;
   logic [FRACTIONAL_WIDTH-1:0] frac_q;
   logic [CW-1:0]               tcnt_q;

   logic cap_fin, cap_to, cap_dbz, tcnt_clr, tcnt_inc;

   // Gating with the live reset keeps s_ready low while reset is held.
   assign s_ready = rstn & ~fifo_full;
   assign push    = s_valid & s_ready;

   div_req_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rstn      (rstn),
      .wr_en_i   (push),
      .wr_data_i ({s_dividend, s_divisor, s_tag}),
      .rd_en_i   (pop),
      .rd_data_o (head),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty)
   );

   assign {h_dvd, h_dvs, h_tag} = head;

   always_ff @(posedge clk) begin
      if (!rstn) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      pop       = 1'b0;
      cap_fin   = 1'b0;
      cap_to    = 1'b0;
      cap_dbz   = 1'b0;
      tcnt_clr  = 1'b0;
      tcnt_inc  = 1'b0;
      div_start = 1'b0;
      m_valid   = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               state_d = (h_dvs == '0) ? BYPASS : LAUNCH;
            end
         end
         LAUNCH: begin
            div_start = 1'b1;
            tcnt_clr  = 1'b1;
            state_d   = WAIT;
         end
         WAIT: begin
            tcnt_inc = 1'b1;
            if (div_finish) begin
               cap_fin = 1'b1;
               state_d = RESULT;
            end else if (tcnt_q == TO_LAST) begin
               cap_to  = 1'b1;
               state_d = RESULT;
            end
         end
         BYPASS: begin
            cap_dbz = 1'b1;
            state_d = RESULT;
         end
         RESULT: begin
            m_valid = 1'b1;
            if (m_ready) state_d = GAP;
         end
         // Lets the divider settle back to idle before the next start.
         GAP:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Operands only change on pop, so they stay put from launch through finish.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         dvd_q  <= '0;
         dvs_q  <= '0;
         tag_q  <= '0;
         rng_q  <= 1'b0;
         quo_q  <= '0;
         frac_q <= '0;
         dbz_q  <= 1'b0;
         to_q   <= 1'b0;
         tcnt_q <= '0;
      end else begin
         if (pop) begin
            dvd_q <= h_dvd;
            dvs_q <= h_dvs;
            tag_q <= h_tag;
            rng_q <= (h_dvd == MOST_NEG) | (h_dvs == MOST_NEG);
         end
         if (cap_fin) begin
            quo_q  <= div_quotient;
            frac_q <= div_fractional;
            dbz_q  <= 1'b0;
            to_q   <= 1'b0;
         end
         if (cap_to) begin
            quo_q  <= '0;
            frac_q <= '0;
            dbz_q  <= 1'b0;
            to_q   <= 1'b1;
         end
         if (cap_dbz) begin
            quo_q  <= dvd_q[DW-1] ? QUOTIENT_WIDTH'(QMIN) : QUOTIENT_WIDTH'(QMAX);
            frac_q <= '0;
            dbz_q  <= 1'b1;
            to_q   <= 1'b0;
         end
         if (tcnt_clr)      tcnt_q <= '0;
         else if (tcnt_inc) tcnt_q <= tcnt_q + 1'b1;
      end
   end

   assign div_dividend = dvd_q;
   assign div_divisor  = dvs_q;
   assign m_quotient   = quo_q;
   assign m_fractional = frac_q;
   assign m_tag        = tag_q;
   assign m_dbz        = dbz_q;
   assign m_timeout    = to_q;
   assign m_range      = rng_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Scoreboard bench for div_issue_ctrl with a behavioural 49-cycle divider model.
module tb_div_issue_ctrl;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        s_valid = 1'b0, s_ready;
   logic [31:0] s_dividend = '0, s_divisor = '0;
   logic [3:0]  s_tag = '0;
   logic        div_start, div_finish;
   logic [31:0] div_dividend, div_divisor, div_quotient;
   logic [15:0] div_fractional;
   logic        m_valid, m_ready = 1'b1;
   logic [31:0] m_quotient;
   logic [15:0] m_fractional;
   logic [3:0]  m_tag;
   logic        m_dbz, m_timeout, m_range;

   localparam logic [31:0] MNEG = 32'h8000_0000;

   div_issue_ctrl dut (
      .clk(clk), .rstn(rstn),
      .s_valid(s_valid), .s_ready(s_ready), .s_dividend(s_dividend),
      .s_divisor(s_divisor), .s_tag(s_tag),
      .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
      .div_quotient(div_quotient), .div_fractional(div_fractional), .div_finish(div_finish),
      .m_valid(m_valid), .m_ready(m_ready), .m_quotient(m_quotient),
      .m_fractional(m_fractional), .m_tag(m_tag), .m_dbz(m_dbz),
      .m_timeout(m_timeout), .m_range(m_range)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0, n_pass = 0;
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
   endtask

   // Reference signed fixed-point division: truncated quotient, fraction magnitude.
   function automatic logic [47:0] calc(input logic [31:0] a, input logic [31:0] b);
      longint la, lb, ma, mb;
      logic [31:0] q;
      logic [15:0] f;
      la = longint'(signed'(a));
      lb = longint'(signed'(b));
      if (lb == 0) return '0;
      ma = (la < 0) ? -la : la;
      mb = (lb < 0) ? -lb : lb;
      q  = 32'(la / lb);
      f  = 16'(((ma % mb) << 16) / mb);
      return {q, f};
   endfunction

   // Divider model: result follows live operands, finish 49 cycles after start.
   logic        fin_en = 1'b1, stray = 1'b0;
   logic        dm_busy = 1'b0, dm_fin = 1'b0;
   int          dm_cnt = 0;
   logic [31:0] dm_a = '0, dm_b = '0;

   assign {div_quotient, div_fractional} = calc(div_dividend, div_divisor);
   assign div_finish = dm_fin | stray;

   always @(posedge clk) begin
      if (!rstn) begin
         dm_busy <= 1'b0;
         dm_fin  <= 1'b0;
         dm_cnt  <= 0;
      end else begin
         dm_fin <= 1'b0;
         if (div_start) begin
            dm_busy <= 1'b1;
            dm_cnt  <= 1;
            dm_a    <= div_dividend;
            dm_b    <= div_divisor;
         end else if (dm_busy) begin
            dm_cnt <= dm_cnt + 1;
            if (dm_cnt == 48) begin
               dm_busy <= 1'b0;
               dm_fin  <= fin_en;
            end
         end
      end
   end

   typedef struct {
      logic [31:0] q;
      logic [15:0] f;
      logic [3:0]  tag;
      logic        dbz, to, rng;
      int          acc;
      int          lat;
   } exp_t;
   exp_t sb[$];
   exp_t mon_e;

   logic mv_prev = 1'b0, ds_prev = 1'b0;
   int   last_fin = -1, n_start = 0, n_rise = 0;

   always @(negedge clk) begin
      if (!rstn) begin
         mv_prev  = 1'b0;
         ds_prev  = 1'b0;
         last_fin = -1;
      end else begin
         if (div_start) begin
            n_start++;
            chk("start_pulse", ds_prev, 1'b0);
            if (last_fin >= 0) chk("gap_before_start", (cyc - last_fin) >= 4, 1'b1);
         end
         if (div_finish && !stray) begin
            chk("op_hold", {div_dividend, div_divisor}, {dm_a, dm_b});
            last_fin = cyc;
         end
         if (m_valid && !mv_prev) begin
            n_rise++;
            if (sb.size() > 0 && sb[0].lat >= 0) chk("latency", cyc - sb[0].acc, sb[0].lat);
         end
         if (m_valid && m_ready) begin
            if (sb.size() == 0) chk("sb_empty", 1'b1, 1'b0);
            else begin
               mon_e = sb.pop_front();
               chk("m_quotient", m_quotient, mon_e.q);
               chk("m_fractional", m_fractional, mon_e.f);
               chk("m_tag", m_tag, mon_e.tag);
               chk("m_dbz", m_dbz, mon_e.dbz);
               chk("m_timeout", m_timeout, mon_e.to);
               chk("m_range", m_range, mon_e.rng);
            end
         end
         mv_prev = m_valid;
         ds_prev = div_start;
      end
   end

   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] t,
                       input logic [31:0] q, input logic [15:0] f,
                       input logic dbz, input logic to, input int lat);
      exp_t e;
      int n;
      s_valid = 1'b1; s_dividend = a; s_divisor = b; s_tag = t;
      n = 0;
      @(negedge clk);
      while (!s_ready && n < 500) begin @(negedge clk); n++; end
      chk("accept", s_ready, 1'b1);
      if (s_ready) begin
         e.q = q; e.f = f; e.tag = t; e.dbz = dbz; e.to = to;
         e.rng = (a == MNEG) || (b == MNEG);
         e.acc = cyc; e.lat = lat;
         sb.push_back(e);
      end
      @(posedge clk); #1;
      s_valid = 1'b0;
   endtask

   task automatic send_calc(input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
      logic [47:0] r;
      r = calc(a, b);
      send(a, b, t, r[47:16], r[15:0], 1'b0, 1'b0, -1);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() > 0 && n < 3000) begin @(negedge clk); n++; end
      chk("drain", sb.size(), 0);
      repeat (3) @(posedge clk);
      #1;
   endtask

   int n0;
   logic [54:0] snap;
   logic stable;

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_s_ready", s_ready, 1'b0);
      chk("rst_div_start", div_start, 1'b0);
      chk("rst_m_valid", m_valid, 1'b0);
      chk("rst_div_ops", {div_dividend, div_divisor}, 64'd0);
      chk("rst_m_data", {m_quotient, m_fractional, m_tag}, 52'd0);
      chk("rst_flags", {m_dbz, m_timeout, m_range}, 3'd0);
      @(posedge clk); #1;
      rstn = 1'b1;
      @(negedge clk);
      chk("ready_after_rst", s_ready, 1'b1);
      @(posedge clk); #1;

      n0 = n_start;
      send(32'd100, 32'd7, 4'd3, 32'd14, 16'h4924, 1'b0, 1'b0, 52);
      drain();
      chk("start_count", n_start - n0, 1);

      send(-32'sd100, 32'd7, 4'd4, 32'hFFFF_FFF2, 16'h4924, 1'b0, 1'b0, 52);
      drain();

      n0 = n_start;
      send(32'd5, 32'd0, 4'd5, 32'h7FFF_FFFF, 16'h0, 1'b1, 1'b0, 3);
      drain();
      send(-32'sd5, 32'd0, 4'd6, 32'h8000_0000, 16'h0, 1'b1, 1'b0, 3);
      drain();
      chk("dbz_no_start", n_start - n0, 0);

      // Keep the divider busy so the FIFO takes exactly four before filling.
      send_calc(32'd1000, 32'd3, 4'd7);
      repeat (5) @(posedge clk);
      #1;
      send_calc(-32'sd77, 32'd5, 4'd8);
      send_calc(32'd12345, -32'sd17, 4'd9);
      send_calc(32'd1, 32'd9, 4'd10);
      send_calc(MNEG, 32'd3, 4'd11);
      chk("full_after_4", s_ready, 1'b0);
      send_calc(32'd7, 32'd7, 4'd12);
      drain();

      m_ready = 1'b0;
      send_calc(32'd20, 32'd3, 4'd13);
      send_calc(32'd9, 32'd4, 4'd14);
      begin
         int n;
         n = 0;
         @(negedge clk);
         while (!m_valid && n < 200) begin @(negedge clk); n++; end
      end
      chk("stall_valid", m_valid, 1'b1);
      snap = {m_quotient, m_fractional, m_tag, m_dbz, m_timeout, m_range};
      n0 = n_start;
      stable = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         stray = (i == 5);
         @(negedge clk);
         if ({m_quotient, m_fractional, m_tag, m_dbz, m_timeout, m_range} !== snap || !m_valid)
            stable = 1'b0;
      end
      stray = 1'b0;
      chk("stall_stable", stable, 1'b1);
      chk("stall_no_start", n_start - n0, 0);
      @(posedge clk); #1;
      m_ready = 1'b1;
      drain();

      fin_en = 1'b0;
      send(32'd9, 32'd3, 4'd15, 32'd0, 16'd0, 1'b0, 1'b1, 67);
      drain();
      fin_en = 1'b1;

      send_calc(32'd100, 32'd7, 4'd1);
      send_calc(32'd50, 32'd7, 4'd2);
      repeat (10) @(posedge clk);
      #1;
      rstn = 1'b0;
      sb.delete();
      @(negedge clk);
      chk("rst_mid_m_valid", m_valid, 1'b0);
      chk("rst_mid_s_ready", s_ready, 1'b0);
      @(posedge clk); #1;
      rstn = 1'b1;
      n0 = n_rise;
      repeat (80) @(posedge clk);
      #1;
      chk("no_stale_result", n_rise - n0, 0);
      send(32'd100, 32'd7, 4'd6, 32'd14, 16'h4924, 1'b0, 1'b0, 52);
      drain();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: bench did not finish");
      $fatal(1);
   end

endmodule

// File: doc/div_issue_ctrl.md
Name: div_issue_ctrl

Overview:
Upstream issue stage for the 48-cycle signed fixed-point divider (divider_48cycle_v3, dispersion output form). It accepts operand pairs over a valid/ready stream and buffers them in a small FIFO. It launches one division at a time with a one-cycle start pulse, holds operands stable until the divider finishes, and returns tagged results over a valid/ready stream. Divide-by-zero is resolved locally without launching the divider. A hang watchdog is included.

Parameters:
DIVISION_WIDTH, 32, operand width (two's complement)
QUOTIENT_WIDTH, 32, integer quotient width from divider
FRACTIONAL_WIDTH, 16, fractional bits from divider
TAG_WIDTH, 4, opaque request tag carried to result
FIFO_DEPTH, 4, request buffer entries (power of 2, >=2)
TIMEOUT, 64, cycles allowed from start to div_finish

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
s_valid  in  1  request valid
s_ready  out  1  request accepted when s_valid&s_ready
s_dividend  in  DIVISION_WIDTH  signed dividend
s_divisor  in  DIVISION_WIDTH  signed divisor
s_tag  in  TAG_WIDTH  request tag
div_start  out  1  one-cycle launch pulse to divider
div_dividend  out  DIVISION_WIDTH  operand to divider, held stable
div_divisor  out  DIVISION_WIDTH  operand to divider, held stable
div_quotient  in  QUOTIENT_WIDTH  divider integer result
div_fractional  in  FRACTIONAL_WIDTH  divider fraction (magnitude)
div_finish  in  1  divider done pulse
m_valid  out  1  result valid
m_ready  in  1  result consumed when m_valid&m_ready
m_quotient  out  QUOTIENT_WIDTH  result integer part
m_fractional  out  FRACTIONAL_WIDTH  result fraction
m_tag  out  TAG_WIDTH  tag of the request
m_dbz  out  1  divisor was zero
m_timeout  out  1  divider failed to finish within TIMEOUT
m_range  out  1  an operand equalled -2^(DIVISION_WIDTH-1); result unreliable

Behaviour:
- Reset (rstn low at a clk edge): FIFO empty; FSM in IDLE; timeout counter 0. Outputs: s_ready=0 during reset, 1 from the first cycle after reset; div_start=0; m_valid=0; div_dividend=div_divisor=0; m_* data=0; all flags 0.
- FIFO: s_ready = !full. Push and pop in the same cycle are allowed when full. Pointers wrap modulo FIFO_DEPTH. A push while full is ignored.
- FSM states and transitions:
  - IDLE: if FIFO non-empty, pop the head into the operand/tag registers. Go to BYPASS if divisor==0, else LAUNCH.
  - LAUNCH: div_start=1 for exactly this cycle. Operands are already on div_* (registered at pop). Clear the timeout counter. Go to WAIT.
  - WAIT: the counter increments each cycle.
    - If div_finish: capture div_quotient/div_fractional in the same cycle, set m_timeout=0, go to RESULT.
    - Else if counter==TIMEOUT-1: capture zeros, set m_timeout=1, go to RESULT.
  - BYPASS: quotient = 2^(QUOTIENT_WIDTH-1)-1 if dividend>=0, else -2^(QUOTIENT_WIDTH-1). Fraction = 0. m_dbz=1. Go to RESULT.
  - RESULT: m_valid=1 with all m_* fields stable. On m_ready, go to GAP.
  - GAP: one mandatory idle cycle so the divider returns to its IDLE state before the next start. Go to IDLE.
- Operand hold: div_dividend/div_divisor must not change from LAUNCH until the cycle after div_finish. The divider derives its output sign combinationally from live operands.
- m_range is set when either operand equals -2^(DIVISION_WIDTH-1). The divider is still launched.
- Minimum request-to-result latency with an idle output: 1 (pop) + 1 (LAUNCH) + divider latency (49 cycles from start to finish) = 51 cycles. A zero-divisor request reaches m_valid 2 cycles after the pop cycle.
- A stray div_finish outside WAIT is ignored.
- Reset mid-operation aborts the transfer: FIFO contents are discarded and no result is produced.
- Sign convention: the result passes through unchanged. The quotient is signed; the fraction is an unsigned magnitude.

Decomposition:
- Shared package div_pkg holds:
  - state encoding (IDLE, LAUNCH, WAIT, BYPASS, RESULT, GAP)
  - saturation constants QMAX/QMIN
  - the clogb2 function, used for FIFO pointer and timeout counter widths.
- One sub-module: div_req_fifo (synchronous, FIFO_DEPTH x (2*DIVISION_WIDTH+TAG_WIDTH), full/empty, first-word-fall-through).

Test Plan:
- 100/7, tag 3 → div_start pulses once; m_quotient=14, m_fractional=0x4924, m_tag=3; m_dbz, m_timeout and m_range all 0.
- -100/7 → m_quotient=-14 (0xFFFFFFF2), m_fractional=0x4924; div_dividend stays 0xFFFFFF9C from start through finish.
- 5/0 then -5/0 → no div_start; results 0x7FFFFFFF and 0x80000000, fraction 0, m_dbz=1, each 2 cycles after pop.
- Five back-to-back requests with m_ready=1 → s_ready drops after the 4th is accepted; results return in order with tags intact; at least 1 GAP cycle between finish and the next div_start.
- m_ready held low for 20 cycles on a result → m_* fields stable; no new div_start until the handshake completes. Divider model never asserting finish → m_timeout=1 after 64 cycles.
- rstn asserted during WAIT → m_valid=0 and FIFO empty the next cycle; a new 100/7 request after reset completes correctly.
